// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP constants and arbiter FSM state encoding
package fp_pkg;
    localparam int             FP_W    = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        // Scan offsets high to low so the smallest offset from ptr is the last write.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req_valid[idx]) begin
                grant_idx = idx;
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin share of one multi-cycle FP adder with watchdog
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]      req_sub,
    output logic                  add_start,
    output logic [FP_W-1:0]       add_a,
    output logic [FP_W-1:0]       add_b,
    output logic                  add_sub,
    input  logic                  add_done,
    input  logic [FP_W-1:0]       add_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int               IDX_W    = $clog2(N_REQ);
    localparam int               WD_W     = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, owner, grant_idx;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [WD_W-1:0]  wdog;
    logic [FP_W-1:0]  sel_a, sel_b;
    logic             sel_sub;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .ptr       (ptr),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*FP_W +: FP_W];
                sel_b   = req_b[i*FP_W +: FP_W];
                sel_sub = req_sub[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_start = 1'b0;
        rsp_valid = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (add_done || wdog == WD_LAST) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A done outside WAIT falls through every branch below and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            wdog     <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_sub  <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        add_a   <= sel_a;
                        add_b   <= sel_b;
                        add_sub <= sel_sub;
                        owner   <= grant_idx;
                    end
                end
                S_ISSUE: wdog <= '0;
                S_WAIT: begin
                    if (add_done) begin
                        rsp_data <= add_result;
                        rsp_err  <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        rsp_data <= FP_QNAN;
                        rsp_err  <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed table-driven bench for fp_add_arbiter
module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_sub, rsp_valid;
    logic [32*N-1:0] req_a, req_b;
    logic            add_start, add_sub, add_done, rsp_err, busy;
    logic [31:0]     add_a, add_b, add_result, rsp_data;
    logic            mdl_done, inj_done;
    logic [31:0]     mdl_result, inj_result;

    int          checks = 0;
    int          failures = 0;
    int          lat = -1;
    bit          echo = 1'b0;
    logic [31:0] cur_a = '0, cur_b = '0, cur_res = '0;
    logic        cur_sub = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        int          r;
        int          lat;
        logic [31:0] res;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_n;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    assign add_done   = mdl_done | inj_done;
    assign add_result = inj_done ? inj_result : mdl_result;

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_done   (add_done),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Adder stand-in: done lands in cycle (start cycle + lat); lat < 0 never answers.
    initial begin
        logic [31:0] res_m;
        mdl_done   = 1'b0;
        mdl_result = '0;
        forever begin
            @(negedge clk);
            if (add_start && lat >= 0) begin
                if (echo) res_m = add_a;
                else if (add_a === cur_a && add_b === cur_b && add_sub === cur_sub) res_m = cur_res;
                else res_m = 32'hDEADBEEF;
                repeat (lat) @(negedge clk);
                mdl_done   = 1'b1;
                mdl_result = res_m;
                @(negedge clk);
                mdl_done   = 1'b0;
                mdl_result = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx);
        vec_t v;
        int   n;
        bit   got;
        bit   stable;
        v = vecs[idx];
        lat = v.lat; echo = 1'b0;
        cur_a = v.a; cur_b = v.b; cur_sub = v.sub; cur_res = v.res;
        @(negedge clk);
        req_a[32*v.r +: 32] = v.a;
        req_b[32*v.r +: 32] = v.b;
        req_sub[v.r]        = v.sub;
        req_valid[v.r]      = 1'b1;
        #1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready[v.r]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk($sformatf("v%0d_grant", idx), 32'(req_ready), 32'(1 << v.r));
        if (!got) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        #1 req_valid[v.r] = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_start", idx), 32'(add_start), 32'd1);
        chk($sformatf("v%0d_add_a", idx), add_a, v.a);
        chk($sformatf("v%0d_add_b", idx), add_b, v.b);
        chk($sformatf("v%0d_add_sub", idx), 32'(add_sub), 32'(v.sub));
        n = 1;
        stable = 1'b1;
        while (rsp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
            if (add_a !== v.a || add_b !== v.b || add_sub !== v.sub) stable = 1'b0;
        end
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.exp_n));
        chk($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'(1 << v.r));
        chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
        chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_operands_stable", idx), 32'(stable), 32'd1);
    endtask

    initial begin
        int          got;
        bit          onehot_ok;
        bit          quiet;
        logic [3:0]  seen[4];
        logic [31:0] dat[4];

        vecs[0] = '{32'h40400000, 32'h40000000, 1'b0, 0, 3,  32'h40A00000, 32'h40A00000, 1'b0, 5};
        vecs[1] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 1, 2,  32'h33800000, 32'h33800000, 1'b0, 4};
        vecs[2] = '{32'h7FA00001, 32'h3F800000, 1'b0, 2, 1,  32'h7FE00001, 32'h7FE00001, 1'b0, 3};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 3, 5,  32'h00000001, 32'h00000001, 1'b0, 7};
        vecs[4] = '{32'h7F800000, 32'hFF800000, 1'b1, 0, -1, 32'h00000000, QNAN,         1'b1, 18};
        vecs[5] = '{32'h40400000, 32'h40000000, 1'b0, 1, 16, 32'h40A00000, 32'h40A00000, 1'b0, 18};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 1'b0, 2, 0,  32'h40000000, QNAN,         1'b1, 18};
        vecs[7] = '{32'h7F800000, 32'hFF800000, 1'b1, 3, 1,  32'h7F800000, 32'h7F800000, 1'b0, 3};
        vecs[8] = '{32'h3F800000, 32'h40000000, 1'b0, 1, 2,  32'h40400000, 32'h40400000, 1'b0, 4};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
        inj_done = 1'b0; inj_result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_add_start", 32'(add_start), 32'd0);
        chk("reset_add_a", add_a, 32'd0);
        chk("reset_add_b", add_b, 32'd0);
        chk("reset_add_sub", 32'(add_sub), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Round-robin: requesters 0 and 2 held valid; adder echoes operand A.
        echo = 1'b1; lat = 1;
        req_a[31:0] = 32'h40400000;
        req_a[95:64] = 32'h40000000;
        req_valid = 4'b0101;
        got = 0; onehot_ok = 1'b1;
        for (int c = 0; c < 200 && got < 4; c++) begin
            @(negedge clk);
            if ($countones(req_ready) > 1) onehot_ok = 1'b0;
            if (rsp_valid != '0) begin
                seen[got] = rsp_valid;
                dat[got]  = rsp_data;
                got++;
                if (got == 4) req_valid = '0;
            end
        end
        chk("rr_count", 32'(got), 32'd4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("rr_owner%0d", i), 32'(seen[i]), (i % 2 == 1) ? 32'h4 : 32'h1);
            chk($sformatf("rr_data%0d", i), dat[i], (i % 2 == 1) ? 32'h40000000 : 32'h40400000);
        end
        chk("rr_ready_onehot", 32'(onehot_ok), 32'd1);
        echo = 1'b0;

        for (int i = 0; i < 9; i++) run_op(i);

        // Stray done while idle must not produce a response.
        @(negedge clk);
        inj_result = 32'h12345678; inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) quiet = 1'b0;
        end
        chk("stray_done_idle", 32'(quiet), 32'd1);

        // Reset mid-WAIT with ptr=2; late done must be dropped and ptr return to 0.
        echo = 1'b1; lat = 10;
        @(negedge clk);
        req_a[95:64] = 32'h40800000;
        req_valid = 4'b0100;
        #1;
        chk("rstw_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        chk("rstw_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_add_a", add_a, 32'd0);
        chk("rstw_add_b", add_b, 32'd0);
        chk("rstw_add_start", 32'(add_start), 32'd0);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) quiet = 1'b0;
        end
        chk("rstw_late_done_ignored", 32'(quiet), 32'd1);
        lat = 1;
        req_valid = 4'b1001;
        #1;
        chk("rstw_next_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = '0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1;
                break;
            end
        end
        chk("rstw_next_rsp", 32'(rsp_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Shares one multi-cycle floating-point add/sub datapath (unpack → align → add → normalise → round) between `N_REQ` requesters, such as the CORDIC x/y/z iteration units. It runs a round-robin grant and a single-outstanding-operation start/done handshake to the adder. Results return to the issuing requester only. A watchdog substitutes a quiet NaN if the adder never completes.

## Interface
- `N_REQ`, 4: number of requesters (≥2)
- `TIMEOUT`, 64: WAIT cycles before watchdog abort (≥2)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester operation request
- `req_ready`  out  N_REQ  per-requester accept, at most one bit high
- `req_a`  in  32·N_REQ  operand A of requester i at [32i+31:32i], IEEE-754 single
- `req_b`  in  32·N_REQ  operand B, same packing
- `req_sub`  in  N_REQ  1 = A−B, 0 = A+B
- `add_start`  out  1  one-cycle start pulse to the adder
- `add_a`, `add_b`  out  32  latched operands, held stable from ISSUE until the op ends
- `add_sub`  out  1  latched op bit, fed to the aligner op input
- `add_done`  in  1  adder completion pulse
- `add_result`  in  32  adder result, valid while `add_done`=1
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse to the owner
- `rsp_data`  out  32  result, valid with `rsp_valid`
- `rsp_err`  out  1  1 = watchdog abort; `rsp_data`=32'h7FC00000
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:** the arbiter selects the first i with `req_valid[i]`, scanning from `ptr` upward modulo N_REQ.
  - `req_ready[i]`=1 for that i only; this is combinational from `ptr` and `req_valid`.
  - On handshake, the FSM latches `req_a[i]`, `req_b[i]`, `req_sub[i]` and `owner`=i, then moves to ISSUE.
- **ISSUE:** `add_start`=1 for exactly this cycle; the FSM then moves to WAIT and clears `wdog`.
- **WAIT:**
  - If `add_done`=1, the FSM latches `add_result` into `rsp_data`, sets `rsp_err`=0, and moves to RESP.
  - Otherwise, if `wdog`==TIMEOUT−1, it sets `rsp_data`=32'h7FC00000 and `rsp_err`=1, then moves to RESP.
  - Otherwise `wdog`++.
- **RESP:** `rsp_valid[owner]`=1 for one cycle; `ptr` ← (owner+1) mod N_REQ; the FSM returns to IDLE.
- Requesters must sample responses on the pulse; there is no back-pressure.
- `add_done` is ignored in IDLE, ISSUE and RESP. A stray or late done never produces a response.
- The controller performs no arithmetic. Operands and result pass through bit-exact, including NaN, Inf, zero and subnormals.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept for it.
- **Reset:**
  - State IDLE, `ptr`=0, `owner`=0, `wdog`=0.
  - All outputs are 0: `req_ready`, `add_start`, `add_a`, `add_b`, `add_sub`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`.
  - Reset mid-operation abandons the op with no response. The adder's later done is ignored.

## Timing
- Handshake at edge k: ISSUE occupies cycle k+1 (`add_start`=1).
- Adder `add_done` arrives at cycle k+1+L, with L≥1: `rsp_valid` is high at cycle k+2+L, IDLE resumes at k+3+L, and the next grant is possible at edge k+3+L.
- If the adder pulses done in the same cycle as `add_start` (L=0), the done is ignored and the op times out.
- Watchdog path: WAIT lasts TIMEOUT cycles and `rsp_valid` rises at cycle k+2+TIMEOUT.
- If `add_done` arrives in the final WAIT cycle, done wins and `rsp_err`=0.
- Minimum grant-to-grant spacing is L+3 cycles; there is one outstanding op at a time.

## Structure
- Shared package `fp_pkg`:
  - `FP_W`=32 and `FP_QNAN`=32'h7FC00000
  - state encoding IDLE=0, ISSUE=1, WAIT=2, RESP=3
- Sub-module `rr_arbiter` (N_REQ, `ptr`, `req_valid` → one-hot grant plus index), purely combinational.
- FSM, latches and watchdog live in the top level.

## Test plan
- **Single op.** Setup: behavioural adder, L=3; req0 = 32'h40400000 + 32'h40000000, `req_sub`=0; handshake at edge k. Required: `add_start` at k+1, `add_a`/`add_b` stable through WAIT, `rsp_valid`=4'b0001 at k+5, `rsp_data`=32'h40A00000, `rsp_err`=0.
- **Round-robin.** Setup: req0 and req2 held valid continuously from reset. Required: grant order 0, 2, 0, 2; responses go only to the matching `rsp_valid` bit.
- **Subtract pass-through.** Setup: req1 = 32'h3F800000 − 32'h3F7FFFFF, `req_sub`=1. Required: `add_sub`=1, and `rsp_data` equals the model result bit-exact (32'h33800000).
- **Watchdog.** Setup: adder never asserts done, TIMEOUT=16. Required: `rsp_valid` at k+18, `rsp_data`=32'h7FC00000, `rsp_err`=1. Then inject a stray `add_done` in IDLE: no response.
- **Reset mid-WAIT.** Setup: assert `rst` during WAIT, then deliver the adder's done after reset. Required: all outputs 0, no `rsp_valid`, next grant goes to requester 0 first.
- **Boundary.** Setup 1: `add_done` coincident with the last WAIT cycle. Required: real result, `rsp_err`=0. Setup 2: `add_done` asserted during ISSUE. Required: ignored.
